stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter MCNT_1S, default 50_000_000-1: terminal value of the 1 s prescaler at 50 MHz.
REQ-002 SHALL have parameter MCNT_20MS, default 1_000_000-1: terminal value of the key debounce counter.
REQ-003 SHALL have port Clk  input  1  system clock; all logic on rising edge; one clock domain.
REQ-004 SHALL have port Reset_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port Key_Start_n  input  1  raw start/stop push-button, active-low, asynchronous to Clk.
REQ-006 SHALL have port Key_Clear_n  input  1  raw clear push-button, active-low, asynchronous to Clk.
REQ-007 SHALL have port Disp_Data  output  8  registered BCD count {tens[7:4], ones[3:0]}; feeds the 2-digit display driver.
REQ-008 SHALL have port Running  output  1  registered; high while the FSM is in RUN.
REQ-009 SHALL have port Wrap  output  1  registered one-cycle pulse when the count rolls 99 -> 00.

Function
REQ-010 Each key SHALL pass a 2-flop synchroniser, then the debounce filter.
REQ-011 Filter: accepts a new level only after the synchronised input differs from the accepted level for MCNT_20MS+1 consecutive cycles; any bounce restarts the count.
REQ-012 Filter SHALL emit a one-cycle press pulse on an accepted 1 -> 0 transition; release produces no pulse.
REQ-013 FSM states SHALL be IDLE, RUN, PAUSE.
REQ-014 Transitions: IDLE+start -> RUN; RUN+start -> PAUSE; PAUSE+start -> RUN; clear in any state -> IDLE.
REQ-015 Start and clear pulses in the same cycle: clear SHALL win.
REQ-016 Prescaler SHALL count 0..MCNT_1S then wrap to 0, advancing only in RUN.
REQ-017 PAUSE: prescaler and count SHALL hold (resume continues the partial second); IDLE: both SHALL be 0.
REQ-018 On the cycle the prescaler equals MCNT_1S in RUN, the count SHALL increment; new value visible on Disp_Data the next cycle.
REQ-019 BCD rule: ones 9 -> 0 with tens+1; tens never exceeds 9; no nibble ever holds A-F.
REQ-020 At 99 with increment: count -> 00, Wrap high for exactly that one cycle, FSM stays RUN.
REQ-021 Clear during the cycle of an increment: count SHALL become 00, Wrap SHALL stay low.
REQ-022 Running SHALL update in the cycle after the state change.

Reset
REQ-023 With Reset_n low at a Clk edge: FSM IDLE; Disp_Data 8'h00; Running 0; Wrap 0; prescaler 0.
REQ-024 Reset: debounce counters 0; synchronisers and accepted levels 1 (released); no press pulse may follow reset release while keys are idle.
REQ-025 Reset mid-count or mid-debounce SHALL discard all progress.

Structure
REQ-026 Shared package SHALL hold the FSM state encoding (2-bit: IDLE=0, RUN=1, PAUSE=2) and default MCNT_1S/MCNT_20MS constants.
REQ-027 Debounce plus edge detect SHALL be sub-module key_filter (parameter MCNT_20MS), instantiated once per key.
REQ-028 FSM, prescaler, BCD counter and output registers SHALL live in stopwatch_ctrl; unreachable state encoding SHALL recover to IDLE.

Verification (bench parameters MCNT_1S=9, MCNT_20MS=3)
REQ-029 Reset, keys high 50 cycles -> Disp_Data 8'h00, Running 0, Wrap 0, no transitions.
REQ-030 Start held low 10 cycles with 2-cycle bounce at onset -> exactly one press; Running 1; Disp_Data 8'h01 after 10 more cycles.
REQ-031 Run to 8'h99, one more 10-cycle period -> Disp_Data 8'h00, single-cycle Wrap, Running stays 1.
REQ-032 Start press at count 8'h37 with prescaler at 5 -> PAUSE holds 8'h37 indefinitely; second press -> next increment 5 cycles after resume, to 8'h38.
REQ-033 Start and clear accepted in the same cycle while RUN at 8'h42 -> IDLE, 8'h00, Running 0.
REQ-034 Reset_n low one cycle at 8'h25 mid-debounce of clear -> 8'h00, IDLE, no later clear pulse from the interrupted press.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: FSM encoding and default
// prescaler / debounce terminal counts for a 50 MHz clock.
package stopwatch_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;

  localparam int MCNT_1S_DEF   = 50_000_000 - 1;
  localparam int MCNT_20MS_DEF = 1_000_000 - 1;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Display-side bundle of the stopwatch: BCD count, run indicator, wrap pulse.
// master drives the bundle, slave (display driver or observer) reads it.
interface stopwatch_ctrl_if;
  logic [7:0] disp_data;
  logic       running;
  logic       wrap;

  modport master (output disp_data, output running, output wrap);
  modport slave  (input disp_data, input running, input wrap);
endinterface

// File: rtl/key_filter.sv
// Push-button conditioner: 2-flop synchroniser, debounce filter, and a
// one-cycle press pulse on an accepted high-to-low transition.
module key_filter #(
  parameter int MCNT_20MS = stopwatch_ctrl_pkg::MCNT_20MS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = (MCNT_20MS > 0) ? $clog2(MCNT_20MS + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MCNT_20MS);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // A new level is taken only after MCNT_20MS+1 consecutive differing
  // samples; any sample matching the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Two-digit BCD stopwatch: start/stop and clear keys drive an IDLE/RUN/PAUSE
// FSM that gates a 1 s prescaler feeding a 00..99 BCD seconds counter.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int MCNT_1S   = MCNT_1S_DEF,
  parameter int MCNT_20MS = MCNT_20MS_DEF
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Key_Start_n,
  input  logic       Key_Clear_n,
  output logic [7:0] Disp_Data,
  output logic       Running,
  output logic       Wrap
);

  localparam int PW = (MCNT_1S > 0) ? $clog2(MCNT_1S + 1) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(MCNT_1S);

  logic          start_press;
  logic          clear_press;
  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic [3:0]    ones;
  logic [3:0]    tens;
  logic          tick;

  key_filter #(.MCNT_20MS(MCNT_20MS)) u_start (
    .clk   (Clk),
    .rst_n (Reset_n),
    .key_n (Key_Start_n),
    .press (start_press)
  );

  key_filter #(.MCNT_20MS(MCNT_20MS)) u_clear (
    .clk   (Clk),
    .rst_n (Reset_n),
    .key_n (Key_Clear_n),
    .press (clear_press)
  );

  assign tick = (state == ST_RUN) && (presc == PRESC_MAX);

  // Clear overrides start; unused encodings fall back to IDLE.
  always_comb begin
    state_nxt = ST_IDLE;
    if (!clear_press) begin
      case (state)
        ST_IDLE:  state_nxt = start_press ? ST_RUN   : ST_IDLE;
        ST_RUN:   state_nxt = start_press ? ST_PAUSE : ST_RUN;
        ST_PAUSE: state_nxt = start_press ? ST_RUN   : ST_PAUSE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state   <= ST_IDLE;
      presc   <= '0;
      ones    <= 4'd0;
      tens    <= 4'd0;
      Running <= 1'b0;
      Wrap    <= 1'b0;
    end else begin
      state   <= state_nxt;
      Running <= (state == ST_RUN);
      Wrap    <= 1'b0;
      if (clear_press || ((state != ST_RUN) && (state != ST_PAUSE))) begin
        presc <= '0;
        ones  <= 4'd0;
        tens  <= 4'd0;
      end else if (state == ST_RUN) begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) begin
          if (ones == 4'd9) begin
            ones <= 4'd0;
            if (tens == 4'd9) begin
              tens <= 4'd0;
              Wrap <= 1'b1;
            end else begin
              tens <= tens + 4'd1;
            end
          end else begin
            ones <= ones + 4'd1;
          end
        end
      end
    end
  end

  assign Disp_Data = {tens, ones};

endmodule
